// File: rtl/nds_dmareq_pkg.sv
// Shared FSM encoding and grant-ID width helper for the DMA request scheduler.
package nds_dmareq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT  = 2'd1,
    BUSY = 2'd2
  } state_e;

  function automatic int id_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/nds_dmareq_sync.sv
// Two-flop synchronizer for one asynchronous peripheral request line.
module nds_dmareq_sync (
  input  logic b_clk,
  input  logic b_reset_n,
  input  logic a_in,
  output logic s_out
);

  logic meta;

  always_ff @(posedge b_clk or negedge b_reset_n) begin
    if (!b_reset_n) begin
      meta  <= 1'b0;
      s_out <= 1'b0;
    end else begin
      meta  <= a_in;
      s_out <= meta;
    end
  end

endmodule

// File: rtl/nds_dmareq_sched.sv
// Round-robin DMA request scheduler: synchronizes peripheral requests, offers one
// grant at a time to the DMA core and returns a four-phase acknowledge per channel.
module nds_dmareq_sched
  import nds_dmareq_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int ID_W   = id_width(NUM_CH)
) (
  input  logic              b_clk,
  input  logic              b_reset_n,
  input  logic [NUM_CH-1:0] a_req,
  input  logic [NUM_CH-1:0] b_ch_en,
  output logic              b_gnt_valid,
  output logic [ID_W-1:0]   b_gnt_id,
  input  logic              b_gnt_ready,
  input  logic              b_xfer_done,
  output logic [NUM_CH-1:0] b_ack
);

  logic [NUM_CH-1:0] s_req, elig, rot;
  logic [ID_W-1:0]   rr_ptr, pick;
  logic              any_elig;
  state_e            state;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_sync
    nds_dmareq_sync u_sync (
      .b_clk     (b_clk),
      .b_reset_n (b_reset_n),
      .a_in      (a_req[i]),
      .s_out     (s_req[i])
    );
  end

  assign elig     = s_req & b_ch_en & ~b_ack;
  assign any_elig = |elig;
  // Rotate so bit 0 is the channel just after rr_ptr; lowest set bit wins.
  assign rot      = NUM_CH'({elig, elig} >> (int'(rr_ptr) + 1));

  always_comb begin
    pick = '0;
    for (int k = NUM_CH - 1; k >= 0; k--)
      if (rot[k]) pick = ID_W'((int'(rr_ptr) + 1 + k) % NUM_CH);
  end

  always_ff @(posedge b_clk or negedge b_reset_n) begin
    if (!b_reset_n) begin
      state       <= IDLE;
      b_gnt_valid <= 1'b0;
      b_gnt_id    <= '0;
      b_ack       <= '0;
      rr_ptr      <= ID_W'(NUM_CH - 1);
    end else begin
      // Release each ack once its request is seen low, regardless of FSM state.
      for (int i = 0; i < NUM_CH; i++)
        if (!s_req[i]) b_ack[i] <= 1'b0;
      case (state)
        IDLE: if (any_elig) begin
          b_gnt_id    <= pick;
          b_gnt_valid <= 1'b1;
          state       <= GNT;
        end
        GNT: if (b_gnt_ready) begin
          b_gnt_valid <= 1'b0;
          state       <= BUSY;
        end else if (!s_req[b_gnt_id] || !b_ch_en[b_gnt_id]) begin
          b_gnt_valid <= 1'b0;
          state       <= IDLE;
        end
        BUSY: if (b_xfer_done) begin
          b_ack[b_gnt_id] <= 1'b1;
          rr_ptr          <= b_gnt_id;
          state           <= IDLE;
        end
        default: begin
          b_gnt_valid <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule
